mac_sequencer: RTL and testbench

Frame-level controller between the UART byte interface and the multiply-accumulate datapath of the neural core. It collects a command frame of N weights and N inputs from the receiver and sequences the external MAC unit through clear and accumulate. It captures the dot-product and streams it back through the transmitter. It drives the `LOAD` and `MULT_DONE` status pins.

---
 rtl/neurocore_pkg.sv | 25 ++
 rtl/operand_buffer.sv | 43 ++++
 rtl/mac_sequencer.sv | 144 ++++++++++++++
 tb/tb_mac_sequencer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/neurocore_pkg.sv
// neurocore_pkg: shared state encoding, frame constants and width helpers for the neural core
package neurocore_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_W,
        S_LOAD_X,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_SEND,
        S_SEND_WAIT
    } state_e;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    function automatic int acc_w(input int n, input int dw);
        return 2 * dw + $clog2(n);
    endfunction

    function automatic int res_bytes(input int n, input int dw);
        return (acc_w(n, dw) + 7) / 8;
    endfunction

endpackage

// File: rtl/operand_buffer.sv
// operand_buffer: weight/input register file with one write port and a registered dual-operand read port
module operand_buffer #(
    parameter int N  = 4,
    parameter int DW = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic                 wr_sel_i,
    input  logic [$clog2(N)-1:0] wr_idx_i,
    input  logic [DW-1:0]        wr_data_i,
    input  logic                 rd_en_i,
    input  logic [$clog2(N)-1:0] rd_k_i,
    output logic [DW-1:0]        rd_a_o,
    output logic [DW-1:0]        rd_b_o
);

    logic [DW-1:0] w_mem [N];
    logic [DW-1:0] x_mem [N];
    logic [DW-1:0] rd_a_q;
    logic [DW-1:0] rd_b_q;

    // store incoming operand byte into the weight or input bank
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !wr_sel_i) w_mem[wr_idx_i] <= wr_data_i;
        if (wr_en_i && wr_sel_i) x_mem[wr_idx_i] <= wr_data_i;
    end

    // registered read; holds the last pair when not enabled
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
        end else if (rd_en_i) begin
            rd_a_q <= w_mem[rd_k_i];
            rd_b_q <= x_mem[rd_k_i];
        end
    end

    assign rd_a_o = rd_a_q;
    assign rd_b_o = rd_b_q;

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: collects a UART operand frame, drives the MAC through clear/accumulate and serialises the result
module mac_sequencer
    import neurocore_pkg::*;
#(
    parameter int N       = 4,
    parameter int DW      = 8,
    parameter int TIMEOUT = 1_000_000,
    localparam int ACC_W  = acc_w(N, DW)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [7:0]       RX_DATA,
    input  logic             RX_VALID,
    output logic [7:0]       TX_DATA,
    output logic             TX_START,
    input  logic             TX_BUSY,
    output logic [DW-1:0]    MAC_A,
    output logic [DW-1:0]    MAC_B,
    output logic             MAC_CLR,
    output logic             MAC_EN,
    input  logic [ACC_W-1:0] MAC_ACC,
    output logic             LOAD,
    output logic             MULT_DONE,
    output logic             ERR
);

    localparam int RB = res_bytes(N, DW);
    localparam int IW = $clog2(N);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int BW = RB > 1 ? $clog2(RB) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [BW-1:0] B_LAST   = BW'(RB - 1);

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [BW-1:0]     b_q, b_d;
    logic [8*RB-1:0]   res_q, res_d;
    logic              err_q, err_d;
    logic [7:0]        hold_q;
    logic              skip_q;
    logic              done_q;

    logic              loading;
    logic              rx_in;
    logic              tmo;
    logic              idx_last;
    logic              tx_go;
    logic              wait_done;
    logic [7:0]        cur_byte;
    logic              rd_en;
    logic [IW-1:0]     rd_k;

    assign loading   = state_q == S_LOAD_W || state_q == S_LOAD_X;
    assign rx_in     = loading && RX_VALID;
    assign tmo       = loading && !RX_VALID && cnt_q == CNT_LAST;
    assign idx_last  = idx_q == IDX_LAST;
    assign tx_go     = state_q == S_SEND && !TX_BUSY;
    assign wait_done = state_q == S_SEND_WAIT && !skip_q && !TX_BUSY;
    assign cur_byte  = res_q[8*(RB-1-int'(b_q)) +: 8];
    assign rd_en     = state_q == S_CLEAR || (state_q == S_RUN && !idx_last);
    assign rd_k      = state_q == S_CLEAR ? '0 : idx_q + IW'(1);

    // prefetch operand k+1 while k is on the MAC so MAC_A/MAC_B line up with MAC_EN
    operand_buffer #(.N(N), .DW(DW)) u_buf (
        .clk_i    (CLK),
        .rst_i    (RESET),
        .wr_en_i  (rx_in),
        .wr_sel_i (state_q == S_LOAD_X),
        .wr_idx_i (idx_q),
        .wr_data_i(RX_DATA),
        .rd_en_i  (rd_en),
        .rd_k_i   (rd_k),
        .rd_a_o   (MAC_A),
        .rd_b_o   (MAC_B)
    );

    // state register
    always_ff @(posedge CLK) begin
        if (RESET) state_q <= S_IDLE;
        else state_q <= state_d;
    end

    // frame sequencing: receive, clear, accumulate, drain, send bytes
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (RX_VALID && RX_DATA == FRAME_HDR) state_d = S_LOAD_W;
            S_LOAD_W:    state_d = tmo ? S_IDLE : (RX_VALID && idx_last) ? S_LOAD_X : S_LOAD_W;
            S_LOAD_X:    state_d = tmo ? S_IDLE : (RX_VALID && idx_last) ? S_CLEAR : S_LOAD_X;
            S_CLEAR:     state_d = S_RUN;
            S_RUN:       if (idx_last) state_d = S_DRAIN;
            S_DRAIN:     state_d = S_SEND;
            S_SEND:      if (!TX_BUSY) state_d = S_SEND_WAIT;
            S_SEND_WAIT: if (wait_done) state_d = b_q == B_LAST ? S_IDLE : S_SEND;
            default:     state_d = S_IDLE;
        endcase
    end

    // status and handshake outputs decoded from the current state
    always_comb begin
        LOAD      = loading;
        MAC_CLR   = state_q == S_CLEAR;
        MAC_EN    = state_q == S_RUN;
        TX_START  = tx_go;
        TX_DATA   = tx_go ? cur_byte : hold_q;
        MULT_DONE = done_q;
        ERR       = err_q;
    end

    // datapath next-state: operand index, idle timer, result capture, byte pointer, sticky error
    always_comb begin
        idx_d = (state_q == S_IDLE || tmo) ? '0 : (rx_in || state_q == S_RUN) ? (idx_last ? '0 : idx_q + IW'(1)) : idx_q;
        cnt_d = (loading && !RX_VALID) ? cnt_q + CW'(1) : '0;
        res_d = state_q == S_DRAIN ? (8*RB)'($signed(MAC_ACC)) : res_q;
        b_d   = state_q == S_DRAIN ? '0 : (wait_done && b_q != B_LAST) ? b_q + BW'(1) : b_q;
        err_d = err_q | tmo | (RX_VALID && !loading && state_q != S_IDLE);
    end

    // datapath registers; TX byte is held after each start until the next one
    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            res_q  <= '0;
            b_q    <= '0;
            err_q  <= 1'b0;
            hold_q <= '0;
            skip_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            b_q    <= b_d;
            err_q  <= err_d;
            hold_q <= tx_go ? cur_byte : hold_q;
            skip_q <= tx_go;
            done_q <= state_q == S_DRAIN;
        end
    end

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: randomized frame bench with behavioural MAC, transmitter and dot-product reference
module tb_mac_sequencer;

    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int TMO   = 40;
    localparam int ACC_W = 2 * DW + $clog2(N);
    localparam int RB    = (ACC_W + 7) / 8;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    logic [7:0] RX_DATA = '0;
    logic RX_VALID = 1'b0;
    logic [7:0] TX_DATA;
    logic TX_START;
    logic TX_BUSY;
    logic [DW-1:0] MAC_A, MAC_B;
    logic MAC_CLR, MAC_EN, LOAD, MULT_DONE, ERR;
    logic signed [ACC_W-1:0] MAC_ACC;
    logic signed [2*DW-1:0] prod;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    int busy_cnt = 0;
    int tx_len = 3;
    int tx_unstable = 0;
    int t_last = 0;
    int clr_q[$], en_q[$], en_cyc_q[$], tx_q[$], tx_cyc_q[$], done_q[$];
    logic [7:0] w_v[N], x_v[N];

    mac_sequencer #(.N(N), .DW(DW), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RESET(RESET), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
        .TX_DATA(TX_DATA), .TX_START(TX_START), .TX_BUSY(TX_BUSY),
        .MAC_A(MAC_A), .MAC_B(MAC_B), .MAC_CLR(MAC_CLR), .MAC_EN(MAC_EN),
        .MAC_ACC(MAC_ACC), .LOAD(LOAD), .MULT_DONE(MULT_DONE), .ERR(ERR)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    assign prod = $signed(MAC_A) * $signed(MAC_B);
    always @(posedge CLK) begin
        if (MAC_CLR) MAC_ACC <= '0;
        else if (MAC_EN) MAC_ACC <= MAC_ACC + ACC_W'(prod);
    end

    assign TX_BUSY = busy_cnt > 0;
    always @(posedge CLK) begin
        if (RESET) busy_cnt <= 0;
        else if (TX_START) busy_cnt <= tx_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end

    always @(negedge CLK) begin
        if (!RESET) begin
            if (MAC_CLR) clr_q.push_back(cyc);
            if (MAC_EN) begin
                en_q.push_back(int'({MAC_A, MAC_B}));
                en_cyc_q.push_back(cyc);
            end
            if (TX_START) begin
                tx_q.push_back(int'(TX_DATA));
                tx_cyc_q.push_back(cyc);
            end
            if (MULT_DONE) done_q.push_back(cyc);
            if (!TX_START && tx_q.size() > 0 && int'(TX_DATA) != tx_q[$]) tx_unstable++;
        end
    end

    task automatic check(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        clr_q.delete(); en_q.delete(); en_cyc_q.delete();
        tx_q.delete(); tx_cyc_q.delete(); done_q.delete();
        tx_unstable = 0;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        RX_VALID = 1'b0;
        @(posedge CLK); #1;
        RESET = 1'b0;
        clear_mon();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        RX_DATA = b;
        RX_VALID = 1'b1;
        @(posedge CLK); #1;
        RX_VALID = 1'b0;
        repeat (gap) begin @(posedge CLK); #1; end
    endtask

    task automatic randomize_vec();
        for (int i = 0; i < N; i++) begin
            w_v[i] = 8'($urandom);
            x_v[i] = 8'($urandom);
        end
    endtask

    task automatic send_frame(input int gmax, input int sp_idx, input int sp_gap);
        for (int i = 0; i <= 2 * N; i++) begin
            logic [7:0] b;
            int g;
            b = i == 0 ? 8'hA5 : i <= N ? w_v[i-1] : x_v[i-N-1];
            g = i == 2 * N ? 0 : i == sp_idx ? sp_gap : int'($urandom_range(gmax, 0));
            if (i == 2 * N) t_last = cyc;
            send_byte(b, g);
        end
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_q.size() < n && k < 400) begin
            @(negedge CLK);
            k++;
        end
        check("tx_count", tx_q.size(), n);
        repeat (tx_len + 4) @(negedge CLK);
    endtask

    task automatic check_frame(input string tag);
        int sum = 0;
        for (int i = 0; i < N; i++) sum += int'($signed(w_v[i])) * int'($signed(x_v[i]));
        wait_tx(RB);
        check({tag, "_clr_cyc"}, clr_q.size() == 1 ? clr_q[0] : -1, t_last + 1);
        check({tag, "_en_count"}, en_q.size(), N);
        for (int k = 0; k < N; k++) begin
            check({tag, "_en_pair"}, k < en_q.size() ? en_q[k] : -1, int'({w_v[k], x_v[k]}));
            check({tag, "_en_cyc"}, k < en_cyc_q.size() ? en_cyc_q[k] : -1, t_last + 2 + k);
        end
        check({tag, "_done_count"}, done_q.size(), 1);
        check({tag, "_done_cyc"}, done_q.size() > 0 ? done_q[0] : -1, t_last + 3 + N);
        check({tag, "_tx0_cyc"}, tx_cyc_q.size() > 0 ? tx_cyc_q[0] : -1, t_last + 3 + N);
        for (int j = 0; j < RB; j++)
            check({tag, "_tx_byte"}, j < tx_q.size() ? tx_q[j] : -1, (sum >>> (8 * (RB - 1 - j))) & 255);
        check({tag, "_mac_a_hold"}, MAC_A, w_v[N-1]);
        check({tag, "_mac_b_hold"}, MAC_B, x_v[N-1]);
        check({tag, "_tx_stable"}, tx_unstable, 0);
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation did not complete");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        clear_mon();
        @(negedge CLK);
        check("reset_outputs", {TX_DATA, TX_START, MAC_A, MAC_B, MAC_CLR, MAC_EN, LOAD, MULT_DONE, ERR}, 0);

        for (int i = 0; i < N; i++) begin
            w_v[i] = 8'(i + 1);
            x_v[i] = 8'(i + 5);
        end
        send_frame(0, -1, 0);
        check_frame("frame_a");

        clear_mon();
        for (int i = 0; i < N; i++) begin
            w_v[i] = 8'hFF;
            x_v[i] = 8'h7F;
        end
        send_frame(2, -1, 0);
        check_frame("frame_neg");

        clear_mon();
        randomize_vec();
        send_byte(8'h00, 1);
        send_byte(8'h5A, 0);
        send_frame(1, -1, 0);
        check_frame("junk_lead");
        check("junk_err", ERR, 0);

        for (int r = 0; r < 6; r++) begin
            clear_mon();
            tx_len = int'($urandom_range(6, 1));
            randomize_vec();
            send_frame(3, -1, 0);
            check_frame("random");
        end
        check("random_err", ERR, 0);

        do_reset();
        randomize_vec();
        send_frame(0, 3, TMO - 1);
        check_frame("tmo_edge");
        check("tmo_edge_err", ERR, 0);

        clear_mon();
        begin
            int s;
            send_byte(8'hA5, 0);
            send_byte(8'h11, 0);
            s = cyc;
            send_byte(8'h22, 0);
            while (cyc < s + TMO) @(negedge CLK);
            check("tmo_load_before", LOAD, 1);
            @(negedge CLK);
            check("tmo_load_after", LOAD, 0);
            check("tmo_err", ERR, 1);
            repeat (10) @(negedge CLK);
            check("tmo_no_en", en_q.size(), 0);
        end
        clear_mon();
        randomize_vec();
        send_frame(1, -1, 0);
        check_frame("after_tmo");

        do_reset();
        tx_len = 50;
        randomize_vec();
        send_frame(1, -1, 0);
        @(posedge CLK); #1;
        RX_DATA = 8'($urandom);
        RX_VALID = 1'b1;
        @(posedge CLK); #1;
        RX_VALID = 1'b0;
        begin
            int k = 0;
            while (tx_q.size() < 1 && k < 100) begin
                @(negedge CLK);
                k++;
            end
        end
        @(posedge CLK); #1;
        tx_len = 2;
        check_frame("busy");
        check("busy_gap", tx_cyc_q.size() > 1 ? tx_cyc_q[1] - tx_cyc_q[0] : -1, 52);
        check("overrun_err", ERR, 1);

        do_reset();
        tx_len = 4;
        randomize_vec();
        send_frame(1, -1, 0);
        begin
            int k = 0;
            while (tx_q.size() < 2 && k < 100) begin
                @(negedge CLK);
                k++;
            end
            check("rst_tx_seen", tx_q.size(), 2);
        end
        @(posedge CLK); #1;
        do_reset();
        @(negedge CLK);
        check("rst_mid_outputs", {TX_DATA, TX_START, MAC_A, MAC_B, MAC_CLR, MAC_EN, LOAD, MULT_DONE, ERR}, 0);
        repeat (30) @(negedge CLK);
        check("rst_no_tx", tx_q.size(), 0);
        check("rst_no_en", en_q.size(), 0);
        clear_mon();
        randomize_vec();
        send_frame(2, -1, 0);
        check_frame("after_rst");
        check("after_rst_err", ERR, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
